// File: rtl/alu_sequencer_if.sv
// Shared types and the grouped command / ALU / memory / response bus for alu_sequencer.
// The slave modport is the sequencer's view; master is the environment's view.
package alu_sequencer_pkg;

   typedef enum logic [5:0] {
      ALU_NOP   = 6'd0,
      ALU_ADD   = 6'd1,
      ALU_ADC   = 6'd2,
      ALU_SUB   = 6'd3,
      ALU_SBC   = 6'd4,
      ALU_AND   = 6'd5,
      ALU_XOR   = 6'd6,
      ALU_OR    = 6'd7,
      ALU_CP    = 6'd8,
      ALU_INC   = 6'd9,
      ALU_DEC   = 6'd10,
      ALU_BIT_0 = 6'd16, ALU_BIT_1 = 6'd17, ALU_BIT_2 = 6'd18, ALU_BIT_3 = 6'd19,
      ALU_BIT_4 = 6'd20, ALU_BIT_5 = 6'd21, ALU_BIT_6 = 6'd22, ALU_BIT_7 = 6'd23,
      ALU_RES_0 = 6'd32, ALU_RES_1 = 6'd33, ALU_RES_2 = 6'd34, ALU_RES_3 = 6'd35,
      ALU_RES_4 = 6'd36, ALU_RES_5 = 6'd37, ALU_RES_6 = 6'd38, ALU_RES_7 = 6'd39,
      ALU_SET_0 = 6'd48, ALU_SET_1 = 6'd49, ALU_SET_2 = 6'd50, ALU_SET_3 = 6'd51,
      ALU_SET_4 = 6'd52, ALU_SET_5 = 6'd53, ALU_SET_6 = 6'd54, ALU_SET_7 = 6'd55
   } alu_op_t;

   typedef struct packed {
      logic z;
      logic n;
      logic h;
      logic c;
   } flags_t;

   typedef logic [7:0] r8_t;

endpackage

interface alu_sequencer_if;
   import alu_sequencer_pkg::*;

   logic        cmd_valid;
   logic        cmd_ready;
   alu_op_t     cmd_op;
   logic        cmd_mem;
   logic        cmd_wide;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic [15:0] cmd_addr;
   flags_t      cmd_flags;

   alu_op_t     alu_op;
   r8_t         alu_op1;
   r8_t         alu_op2;
   flags_t      alu_in_flags;
   r8_t         alu_result;
   flags_t      alu_out_flags;

   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   flags_t      rsp_flags;
   logic        rsp_err;

   modport slave (
      input  cmd_valid, cmd_op, cmd_mem, cmd_wide, cmd_a, cmd_b, cmd_addr, cmd_flags,
      output cmd_ready,
      output alu_op, alu_op1, alu_op2, alu_in_flags,
      input  alu_result, alu_out_flags,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack,
      output rsp_valid, rsp_result, rsp_flags, rsp_err,
      input  rsp_ready
   );

   modport master (
      output cmd_valid, cmd_op, cmd_mem, cmd_wide, cmd_a, cmd_b, cmd_addr, cmd_flags,
      input  cmd_ready,
      input  alu_op, alu_op1, alu_op2, alu_in_flags,
      output alu_result, alu_out_flags,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack,
      input  rsp_valid, rsp_result, rsp_flags, rsp_err,
      output rsp_ready
   );

endinterface

// File: rtl/alu_sequencer.sv
// Sequences one command through an external 8-bit ALU: optional memory read-modify-write,
// 16-bit ADD split over two ALU steps, and a held response. All outputs are registered.
module alu_sequencer
   import alu_sequencer_pkg::*;
(
   input logic            clk,
   input logic            rst_n,
   alu_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle, StMemRd, StExecLo, StExecHi, StMemWr, StResp
   } state_e;

   state_e      state_q, state_d;
   alu_op_t     op_q, op_d;
   logic        mem_q, mem_d;
   logic        wide_q, wide_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   flags_t      flags_q, flags_d;
   r8_t         lo_q, lo_d;

   logic        cmd_ready_q, cmd_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [15:0] rsp_result_q, rsp_result_d;
   flags_t      rsp_flags_q, rsp_flags_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;
   alu_op_t     alu_op_q, alu_op_d;
   r8_t         alu_op1_q, alu_op1_d;
   r8_t         alu_op2_q, alu_op2_d;
   flags_t      alu_in_flags_q, alu_in_flags_d;

   function automatic logic is_bit(alu_op_t op);
      return op[5:3] == 3'b010;
   endfunction

   function automatic logic is_res_set(alu_op_t op);
      return (op[5:3] == 3'b100) || (op[5:3] == 3'b110);
   endfunction

   // BIT keeps the caller's carry; RES/SET leave all flags untouched.
   function automatic flags_t merge_flags(alu_op_t op, flags_t alu_f, flags_t cmd_f);
      flags_t f;
      f = alu_f;
      if (is_bit(op)) f.c = cmd_f.c;
      else if (is_res_set(op)) f = cmd_f;
      return f;
   endfunction

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      mem_d          = mem_q;
      wide_d         = wide_q;
      a_d            = a_q;
      b_d            = b_q;
      flags_d        = flags_q;
      lo_d           = lo_q;
      cmd_ready_d    = cmd_ready_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_err_d      = rsp_err_q;
      rsp_result_d   = rsp_result_q;
      rsp_flags_d    = rsp_flags_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      alu_op_d       = alu_op_q;
      alu_op1_d      = alu_op1_q;
      alu_op2_d      = alu_op2_q;
      alu_in_flags_d = alu_in_flags_q;

      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid) begin
               op_d        = bus.cmd_op;
               mem_d       = bus.cmd_mem;
               wide_d      = bus.cmd_wide;
               a_d         = bus.cmd_a;
               b_d         = bus.cmd_b;
               flags_d     = bus.cmd_flags;
               mem_addr_d  = bus.cmd_addr;
               cmd_ready_d = 1'b0;
               if (bus.cmd_wide && (bus.cmd_op != ALU_ADD || bus.cmd_mem)) begin
                  state_d      = StResp;
                  rsp_valid_d  = 1'b1;
                  rsp_err_d    = 1'b1;
                  rsp_result_d = '0;
                  rsp_flags_d  = bus.cmd_flags;
               end else if (bus.cmd_mem) begin
                  state_d   = StMemRd;
                  mem_req_d = 1'b1;
                  mem_we_d  = 1'b0;
               end else begin
                  state_d        = StExecLo;
                  alu_op_d       = bus.cmd_op;
                  alu_op1_d      = bus.cmd_a[7:0];
                  alu_op2_d      = bus.cmd_b[7:0];
                  alu_in_flags_d = bus.cmd_flags;
               end
            end
         end
         StMemRd: begin
            if (bus.mem_ack) begin
               state_d        = StExecLo;
               mem_req_d      = 1'b0;
               alu_op_d       = op_q;
               alu_op1_d      = bus.mem_rdata;
               alu_op2_d      = b_q[7:0];
               alu_in_flags_d = flags_q;
            end
         end
         StExecLo: begin
            alu_op_d = ALU_NOP;
            if (wide_q) begin
               state_d          = StExecHi;
               lo_d             = bus.alu_result;
               alu_op_d         = ALU_ADC;
               alu_op1_d        = a_q[15:8];
               alu_op2_d        = b_q[15:8];
               alu_in_flags_d   = flags_q;
               alu_in_flags_d.c = bus.alu_out_flags.c;
            end else begin
               rsp_result_d = {8'h00, bus.alu_result};
               rsp_flags_d  = merge_flags(op_q, bus.alu_out_flags, flags_q);
               if (mem_q && op_q != ALU_CP && !is_bit(op_q)) begin
                  state_d     = StMemWr;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_wdata_d = bus.alu_result;
               end else begin
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
               end
            end
         end
         StExecHi: begin
            state_d       = StResp;
            alu_op_d      = ALU_NOP;
            rsp_valid_d   = 1'b1;
            rsp_result_d  = {bus.alu_result, lo_q};
            rsp_flags_d.z = flags_q.z;
            rsp_flags_d.n = 1'b0;
            rsp_flags_d.h = bus.alu_out_flags.h;
            rsp_flags_d.c = bus.alu_out_flags.c;
         end
         StMemWr: begin
            if (bus.mem_ack) begin
               state_d     = StResp;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               rsp_valid_d = 1'b1;
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               state_d     = StIdle;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               cmd_ready_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         op_q           <= ALU_NOP;
         mem_q          <= 1'b0;
         wide_q         <= 1'b0;
         a_q            <= '0;
         b_q            <= '0;
         flags_q        <= '0;
         lo_q           <= '0;
         cmd_ready_q    <= 1'b1;
         rsp_valid_q    <= 1'b0;
         rsp_err_q      <= 1'b0;
         rsp_result_q   <= '0;
         rsp_flags_q    <= '0;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         alu_op_q       <= ALU_NOP;
         alu_op1_q      <= '0;
         alu_op2_q      <= '0;
         alu_in_flags_q <= '0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         mem_q          <= mem_d;
         wide_q         <= wide_d;
         a_q            <= a_d;
         b_q            <= b_d;
         flags_q        <= flags_d;
         lo_q           <= lo_d;
         cmd_ready_q    <= cmd_ready_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_err_q      <= rsp_err_d;
         rsp_result_q   <= rsp_result_d;
         rsp_flags_q    <= rsp_flags_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         alu_op_q       <= alu_op_d;
         alu_op1_q      <= alu_op1_d;
         alu_op2_q      <= alu_op2_d;
         alu_in_flags_q <= alu_in_flags_d;
      end
   end

   assign bus.cmd_ready    = cmd_ready_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_err      = rsp_err_q;
   assign bus.rsp_result   = rsp_result_q;
   assign bus.rsp_flags    = rsp_flags_q;
   assign bus.mem_req      = mem_req_q;
   assign bus.mem_we       = mem_we_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.alu_op       = alu_op_q;
   assign bus.alu_op1      = alu_op1_q;
   assign bus.alu_op2      = alu_op2_q;
   assign bus.alu_in_flags = alu_in_flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: behavioural 8-bit ALU, memory write monitor,
// hand-computed expectations checked on falling clock edges.
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;
   int   wr_cnt = 0;
   int   req_cnt = 0;
   int   base;
   logic [15:0] wr_addr = '0;
   logic [7:0]  wr_data = '0;

   logic [8:0] sum;
   logic [8:0] diff;
   logic [4:0] hsum;
   logic       cin;
   logic [2:0] bit_n;

   alu_sequencer_if bus ();

   alu_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_req) req_cnt <= req_cnt + 1;
      if (bus.mem_req && bus.mem_we && bus.mem_ack) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= bus.mem_addr;
         wr_data <= bus.mem_wdata;
      end
   end

   // Behavioural ALU; RES/SET deliberately return zero flags so the merge is visible.
   always_comb begin
      cin               = 1'b0;
      sum               = '0;
      hsum              = '0;
      diff              = '0;
      bit_n             = bus.alu_op[2:0];
      bus.alu_result    = bus.alu_op1;
      bus.alu_out_flags = '0;
      case (bus.alu_op)
         ALU_ADD, ALU_ADC: begin
            cin  = (bus.alu_op == ALU_ADC) ? bus.alu_in_flags.c : 1'b0;
            sum  = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2} + {8'h00, cin};
            hsum = {1'b0, bus.alu_op1[3:0]} + {1'b0, bus.alu_op2[3:0]} + {4'h0, cin};
            bus.alu_result      = sum[7:0];
            bus.alu_out_flags.z = (sum[7:0] == 8'h00);
            bus.alu_out_flags.h = hsum[4];
            bus.alu_out_flags.c = sum[8];
         end
         ALU_SUB, ALU_CP: begin
            diff = {1'b0, bus.alu_op1} - {1'b0, bus.alu_op2};
            if (bus.alu_op == ALU_SUB) bus.alu_result = diff[7:0];
            bus.alu_out_flags.z = (diff[7:0] == 8'h00);
            bus.alu_out_flags.n = 1'b1;
            bus.alu_out_flags.h = (bus.alu_op1[3:0] < bus.alu_op2[3:0]);
            bus.alu_out_flags.c = diff[8];
         end
         default: begin
            if (bus.alu_op[5:3] == 3'b010) begin
               bus.alu_out_flags.z = ~bus.alu_op1[bit_n];
               bus.alu_out_flags.h = 1'b1;
               bus.alu_out_flags.c = bus.alu_in_flags.c;
            end else if (bus.alu_op[5:3] == 3'b100) begin
               bus.alu_result = bus.alu_op1 & ~(8'h01 << bit_n);
            end else if (bus.alu_op[5:3] == 3'b110) begin
               bus.alu_result = bus.alu_op1 | (8'h01 << bit_n);
            end
         end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input alu_op_t op, input logic mem, input logic wide,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] addr,
                       input logic [3:0] f);
      check("cmd_ready_before_send", 32'(bus.cmd_ready), 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_mem   = mem;
      bus.cmd_wide  = wide;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_addr  = addr;
      bus.cmd_flags = f;
      tick(1);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic release_rsp(input string tag);
      bus.rsp_ready = 1'b1;
      tick(1);
      bus.rsp_ready = 1'b0;
      check({tag, "_rsp_dropped"}, 32'(bus.rsp_valid), 0);
      check({tag, "_cmd_ready_back"}, 32'(bus.cmd_ready), 1);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = ALU_NOP;
      bus.cmd_mem   = 1'b0;
      bus.cmd_wide  = 1'b0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_addr  = '0;
      bus.cmd_flags = '0;
      bus.mem_rdata = '0;
      bus.mem_ack   = 1'b0;
      bus.rsp_ready = 1'b0;
      rst_n         = 1'b0;

      #12;
      check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_err", 32'(bus.rsp_err), 0);
      check("rst_rsp_result", 32'(bus.rsp_result), 0);
      check("rst_rsp_flags", 32'(bus.rsp_flags), 0);
      check("rst_mem", 32'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 0);
      check("rst_alu_op", 32'(bus.alu_op), 32'(ALU_NOP));
      check("rst_alu_ops", 32'({bus.alu_op1, bus.alu_op2, bus.alu_in_flags}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);

      // Register ADD 0x3A + 0xC6
      send(ALU_ADD, 1'b0, 1'b0, 16'h003A, 16'h00C6, 16'h1234, 4'h0);
      check("add_alu_op", 32'(bus.alu_op), 32'(ALU_ADD));
      check("add_op1", 32'(bus.alu_op1), 'h3A);
      check("add_op2", 32'(bus.alu_op2), 'hC6);
      check("add_cmd_ready_low", 32'(bus.cmd_ready), 0);
      check("add_not_yet_valid", 32'(bus.rsp_valid), 0);
      tick(1);
      check("add_valid", 32'(bus.rsp_valid), 1);
      check("add_result", 32'(bus.rsp_result), 'h0000);
      check("add_flags", 32'(bus.rsp_flags), 'hB);
      check("add_err", 32'(bus.rsp_err), 0);
      check("add_alu_nop", 32'(bus.alu_op), 32'(ALU_NOP));
      release_rsp("add");

      // Wide ADD 0x0FFF + 0x0001
      send(ALU_ADD, 1'b0, 1'b1, 16'h0FFF, 16'h0001, 16'h0000, 4'h8);
      check("wide_lo_op", 32'(bus.alu_op), 32'(ALU_ADD));
      check("wide_lo_op1", 32'(bus.alu_op1), 'hFF);
      tick(1);
      check("wide_hi_op", 32'(bus.alu_op), 32'(ALU_ADC));
      check("wide_hi_operands", 32'({bus.alu_op1, bus.alu_op2}), 'h0F00);
      check("wide_hi_in_flags", 32'(bus.alu_in_flags), 'h9);
      check("wide_not_yet_valid", 32'(bus.rsp_valid), 0);
      tick(1);
      check("wide_valid", 32'(bus.rsp_valid), 1);
      check("wide_result", 32'(bus.rsp_result), 'h1000);
      check("wide_flags", 32'(bus.rsp_flags), 'hA);
      release_rsp("wide");

      // Memory SET_3 at 0xC000 with two-cycle ack delays
      base = wr_cnt;
      send(ALU_SET_3, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hC000, 4'h5);
      check("set_rd_req", 32'({bus.mem_req, bus.mem_we}), 'b10);
      check("set_rd_addr", 32'(bus.mem_addr), 'hC000);
      for (int i = 0; i < 2; i++) begin
         tick(1);
         check("set_rd_hold", 32'({bus.mem_req, bus.mem_addr}), 'h1C000);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 8'h00;
      tick(1);
      bus.mem_ack = 1'b0;
      check("set_exec_req_low", 32'(bus.mem_req), 0);
      check("set_exec_op", 32'(bus.alu_op), 32'(ALU_SET_3));
      tick(1);
      check("set_wr_req", 32'({bus.mem_req, bus.mem_we}), 'b11);
      check("set_wr_addr_data", 32'({bus.mem_addr, bus.mem_wdata}), 'hC00008);
      for (int i = 0; i < 2; i++) begin
         tick(1);
         check("set_wr_hold", 32'({bus.mem_req, bus.mem_addr, bus.mem_wdata}), 'h1C00008);
         check("set_wr_no_rsp", 32'(bus.rsp_valid), 0);
      end
      bus.mem_ack = 1'b1;
      tick(1);
      bus.mem_ack = 1'b0;
      check("set_req_dropped", 32'(bus.mem_req), 0);
      check("set_valid", 32'(bus.rsp_valid), 1);
      check("set_result", 32'(bus.rsp_result), 'h0008);
      check("set_flags", 32'(bus.rsp_flags), 'h5);
      check("set_wr_count", 32'(wr_cnt), 32'(base + 1));
      check("set_wr_seen", 32'({wr_addr, wr_data}), 'hC00008);
      release_rsp("set");

      // Memory BIT_7 at 0xD000, no write-back
      base = wr_cnt;
      send(ALU_BIT_7, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hD000, 4'h1);
      check("bit_rd_addr", 32'(bus.mem_addr), 'hD000);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 8'h7F;
      tick(1);
      bus.mem_ack = 1'b0;
      check("bit_exec_op", 32'(bus.alu_op), 32'(ALU_BIT_7));
      tick(1);
      check("bit_valid", 32'(bus.rsp_valid), 1);
      check("bit_no_req", 32'(bus.mem_req), 0);
      check("bit_result", 32'(bus.rsp_result), 'h007F);
      check("bit_flags", 32'(bus.rsp_flags), 'hB);
      check("bit_no_write", 32'(wr_cnt), 32'(base));
      release_rsp("bit");

      // Register RES_1: flags pass through from the command
      send(ALU_RES_1, 1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h0000, 4'hA);
      tick(1);
      check("res_result", 32'(bus.rsp_result), 'h00FD);
      check("res_flags", 32'(bus.rsp_flags), 'hA);
      release_rsp("res");

      // Illegal wide SUB, response held under back-pressure
      base = req_cnt;
      send(ALU_SUB, 1'b0, 1'b1, 16'h1234, 16'h0034, 16'h0000, 4'h6);
      check("ill_valid", 32'(bus.rsp_valid), 1);
      check("ill_err", 32'(bus.rsp_err), 1);
      check("ill_result", 32'(bus.rsp_result), 0);
      check("ill_flags", 32'(bus.rsp_flags), 'h6);
      check("ill_alu_nop", 32'(bus.alu_op), 32'(ALU_NOP));
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("ill_hold", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_result, bus.rsp_flags}),
               'h300006);
         check("ill_cmd_ready_low", 32'(bus.cmd_ready), 0);
      end
      check("ill_no_mem_req", 32'(req_cnt), 32'(base));
      release_rsp("ill");
      check("ill_err_cleared", 32'(bus.rsp_err), 0);

      // Stray mem_ack in IDLE
      bus.mem_ack = 1'b1;
      tick(2);
      bus.mem_ack = 1'b0;
      check("idle_ack_ignored", 32'({bus.mem_req, bus.cmd_ready, bus.rsp_valid}), 'b010);

      // Reset during MEM_WR
      base = wr_cnt;
      send(ALU_ADD, 1'b1, 1'b0, 16'h0000, 16'h0005, 16'h8000, 4'h0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 8'h10;
      tick(1);
      bus.mem_ack = 1'b0;
      tick(1);
      check("rmw_wr_req", 32'({bus.mem_req, bus.mem_we}), 'b11);
      check("rmw_wr_data", 32'(bus.mem_wdata), 'h15);
      rst_n = 1'b0;
      #1;
      check("rmw_rst_mem", 32'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 0);
      check("rmw_rst_cmd_ready", 32'(bus.cmd_ready), 1);
      check("rmw_rst_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_result, bus.rsp_flags}), 0);
      check("rmw_rst_alu", 32'(bus.alu_op), 32'(ALU_NOP));
      bus.mem_ack = 1'b1;
      tick(1);
      rst_n       = 1'b1;
      bus.mem_ack = 1'b0;
      tick(3);
      check("rmw_no_rsp", 32'({bus.rsp_valid, bus.mem_req}), 0);
      check("rmw_no_write", 32'(wr_cnt), 32'(base));

      // Next command completes normally
      send(ALU_SUB, 1'b0, 1'b0, 16'h0010, 16'h0020, 16'h0000, 4'h0);
      tick(1);
      check("post_valid", 32'(bus.rsp_valid), 1);
      check("post_result", 32'(bus.rsp_result), 'h00F0);
      check("post_flags", 32'(bus.rsp_flags), 'h5);
      release_rsp("post");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
